// File: rtl/control_pkg.sv
// Shared opcode map, control-field encodings and types for control_pipe.
// Opcode legality helper is used only when ILLEGAL_TRAP_EN is defined.
package control_pkg;

  localparam logic [3:0] OP_NOP    = 4'b0000;
  localparam logic [3:0] OP_STORE  = 4'b0011;
  localparam logic [3:0] OP_ADD    = 4'b0100;
  localparam logic [3:0] OP_INC    = 4'b0101;
  localparam logic [3:0] OP_NEG    = 4'b0110;
  localparam logic [3:0] OP_SUB    = 4'b0111;
  localparam logic [3:0] OP_JUMP   = 4'b1000;
  localparam logic [3:0] OP_BRZ    = 4'b1001;
  localparam logic [3:0] OP_JMEM   = 4'b1010;
  localparam logic [3:0] OP_BRN    = 4'b1011;
  localparam logic [3:0] OP_LOAD   = 4'b1110;
  localparam logic [3:0] OP_SAVEPC = 4'b1111;

  localparam logic [2:0] ALU_NONE = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b100;
  localparam logic [2:0] ALU_NEG  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b001;

  localparam logic [1:0] WB_PC  = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_ALU = 2'b10;

  typedef struct packed {
    logic [2:0] alu_op;
    logic       alu_src;
    logic       branch_zero;
    logic       branch_neg;
    logic       jump;
    logic       jump_mem;
    logic       mem_read;
    logic       mem_write;
    logic       reg_wrt;
    logic [1:0] wb_ctl;
  } ctrl_t;

  // Only the fields still needed downstream travel past EX.
  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       reg_wrt;
    logic [1:0] wb_ctl;
  } mem_ctrl_t;

  typedef struct packed {
    logic       reg_wrt;
    logic [1:0] wb_ctl;
  } wb_ctrl_t;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HAZ  = 2'd1,
    ST_JMEM = 2'd2
  } state_e;

  localparam ctrl_t     CTRL_NOP = ctrl_t'({$bits(ctrl_t){1'b0}});
  localparam mem_ctrl_t MEM_NOP  = mem_ctrl_t'({$bits(mem_ctrl_t){1'b0}});
  localparam wb_ctrl_t  WB_NOP   = wb_ctrl_t'({$bits(wb_ctrl_t){1'b0}});

  function automatic logic op_defined(input logic [3:0] op);
    case (op)
      OP_NOP, OP_STORE, OP_ADD, OP_INC, OP_NEG, OP_SUB,
      OP_JUMP, OP_BRZ, OP_JMEM, OP_BRN, OP_LOAD, OP_SAVEPC: op_defined = 1'b1;
      default:                                              op_defined = 1'b0;
    endcase
  endfunction

  // A load is the only EX instruction whose result arrives too late to forward.
  function automatic logic is_load(input ctrl_t c);
    return c.mem_read && c.reg_wrt;
  endfunction

endpackage

// File: rtl/control_decode.sv
// Combinational opcode-to-control table for control_pipe.
// With ILLEGAL_TRAP_EN defined, undefined or out-of-range opcodes raise illegal_o.
module control_decode
  import control_pkg::*;
#(
  parameter int OPCODE_W = 4
) (
  input  logic [OPCODE_W-1:0] opcode_i,
  output ctrl_t               ctrl_o,
  output logic                illegal_o
);

  logic       upper_set_s;
  logic [3:0] op_lo_s;
  ctrl_t      table_s;

  assign upper_set_s = (opcode_i >> 3'd4) != {OPCODE_W{1'b0}};
  assign op_lo_s     = opcode_i[3:0];

  // Decode table; anything not listed decodes as nop.
  always_comb begin
    table_s = CTRL_NOP;
    case (op_lo_s)
      OP_SAVEPC: begin
        table_s.reg_wrt = 1'b1;
        table_s.wb_ctl  = WB_PC;
      end
      OP_LOAD: begin
        table_s.mem_read = 1'b1;
        table_s.reg_wrt  = 1'b1;
        table_s.wb_ctl   = WB_MEM;
      end
      OP_STORE: table_s.mem_write = 1'b1;
      OP_ADD: begin
        table_s.alu_op  = ALU_ADD;
        table_s.reg_wrt = 1'b1;
        table_s.wb_ctl  = WB_ALU;
      end
      OP_INC: begin
        table_s.alu_op  = ALU_ADD;
        table_s.alu_src = 1'b1;
        table_s.reg_wrt = 1'b1;
        table_s.wb_ctl  = WB_ALU;
      end
      OP_NEG: begin
        table_s.alu_op  = ALU_NEG;
        table_s.reg_wrt = 1'b1;
        table_s.wb_ctl  = WB_ALU;
      end
      OP_SUB: begin
        table_s.alu_op  = ALU_SUB;
        table_s.reg_wrt = 1'b1;
        table_s.wb_ctl  = WB_ALU;
      end
      OP_JUMP: table_s.jump = 1'b1;
      OP_BRZ: begin
        table_s.alu_op      = ALU_SUB;
        table_s.branch_zero = 1'b1;
      end
      OP_BRN: begin
        table_s.alu_op     = ALU_SUB;
        table_s.branch_neg = 1'b1;
      end
      OP_JMEM: begin
        table_s.mem_read = 1'b1;
        table_s.jump     = 1'b1;
        table_s.jump_mem = 1'b1;
      end
      OP_NOP:  table_s = CTRL_NOP;
      default: table_s = CTRL_NOP;
    endcase
  end

  assign ctrl_o = upper_set_s ? CTRL_NOP : table_s;

`ifdef ILLEGAL_TRAP_EN
  assign illegal_o = upper_set_s || !op_defined(op_lo_s);
`else
  assign illegal_o = 1'b0;
`endif

endmodule

// File: rtl/control_pipe.sv
// Pipelined control path: ID decode, EX/MEM/WB control registers, load-use and jumpMem sequencing.
// Build option ILLEGAL_TRAP_EN turns illegal opcodes into bubbles and raises sticky illegalOp.
module control_pipe
  import control_pkg::*;
#(
  parameter int OPCODE_W   = 4,
  parameter int REG_ADDR_W = 6,
  parameter int ALUOP_W    = 3,
  parameter int JMEM_LAT   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  idValid,
  input  logic [OPCODE_W-1:0]   opcode,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [REG_ADDR_W-1:0] rt,
  input  logic                  memStall,
  input  logic                  redirect,
  output logic                  idReady,
  output logic                  exValid,
  output logic [ALUOP_W-1:0]    exAluOp,
  output logic                  exAluSrc,
  output logic                  exBranchZero,
  output logic                  exBranchNeg,
  output logic                  exJump,
  output logic                  exJumpMem,
  output logic [REG_ADDR_W-1:0] exRd,
  output logic                  memValid,
  output logic                  memRead,
  output logic                  memWrite,
  output logic [REG_ADDR_W-1:0] memRd,
  output logic                  wbValid,
  output logic [1:0]            wbControl,
  output logic                  wbRegWrt,
  output logic [REG_ADDR_W-1:0] wbRd,
  output logic                  illegalOp
);

  localparam int CNT_W = $clog2(JMEM_LAT + 1);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic                    ex_valid_q, ex_valid_d;
  ctrl_t                   ex_ctrl_q, ex_ctrl_d;
  logic [REG_ADDR_W-1:0]   ex_rd_q, ex_rd_d;
  logic                    mem_valid_q, mem_valid_d;
  mem_ctrl_t               mem_ctrl_q, mem_ctrl_d;
  logic [REG_ADDR_W-1:0]   mem_rd_q, mem_rd_d;
  logic                    wb_valid_q, wb_valid_d;
  wb_ctrl_t                wb_ctrl_q, wb_ctrl_d;
  logic [REG_ADDR_W-1:0]   wb_rd_q, wb_rd_d;
  logic                    ill_q, ill_d;

  ctrl_t                   id_ctrl_s;
  logic                    id_illegal_s;
  logic                    load_use_s;
  logic                    ready_s;
  logic                    accept_s;
  logic                    issue_s;

  control_decode #(
    .OPCODE_W (OPCODE_W)
  ) u_decode (
    .opcode_i  (opcode),
    .ctrl_o    (id_ctrl_s),
    .illegal_o (id_illegal_s)
  );

  assign load_use_s = ex_valid_q && is_load(ex_ctrl_q) && idValid &&
                      ((ex_rd_q == rs) || (ex_rd_q == rt));
  assign accept_s   = ready_s && idValid;
  // Illegal opcodes are still consumed from ID; they just never reach EX.
  assign issue_s    = accept_s && !id_illegal_s;

  // FSM state and jumpMem countdown register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (memStall) begin
      state_d = state_q;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (redirect) begin
            state_d = ST_RUN;
          end else if (load_use_s) begin
            state_d = ST_HAZ;
          end else if (accept_s && id_ctrl_s.jump_mem) begin
            state_d = ST_JMEM;
            cnt_d   = CNT_W'(JMEM_LAT);
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_HAZ: begin
          if (accept_s && id_ctrl_s.jump_mem) begin
            state_d = ST_JMEM;
            cnt_d   = CNT_W'(JMEM_LAT);
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_JMEM: begin
          if (redirect || (cnt_q == CNT_W'(1))) begin
            state_d = ST_RUN;
            cnt_d   = {CNT_W{1'b0}};
          end else begin
            cnt_d   = cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_RUN;
          cnt_d   = {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // FSM output: whether ID may hand over its instruction this cycle.
  always_comb begin
    ready_s = 1'b0;
    if (memStall || redirect) begin
      ready_s = 1'b0;
    end else begin
      case (state_q)
        ST_RUN:  ready_s = !load_use_s;
        ST_HAZ:  ready_s = 1'b1;
        ST_JMEM: ready_s = 1'b0;
        default: ready_s = 1'b0;
      endcase
    end
  end

  // Stage-register next values: hold on stall, otherwise shift with EX fed by issue or bubble.
  always_comb begin
    ex_valid_d  = ex_valid_q;
    ex_ctrl_d   = ex_ctrl_q;
    ex_rd_d     = ex_rd_q;
    mem_valid_d = mem_valid_q;
    mem_ctrl_d  = mem_ctrl_q;
    mem_rd_d    = mem_rd_q;
    wb_valid_d  = wb_valid_q;
    wb_ctrl_d   = wb_ctrl_q;
    wb_rd_d     = wb_rd_q;
    ill_d       = ill_q;
    if (memStall) begin
      ill_d = ill_q;
    end else begin
      if (issue_s) begin
        ex_valid_d = 1'b1;
        ex_ctrl_d  = id_ctrl_s;
        ex_rd_d    = rd;
      end else begin
        ex_valid_d = 1'b0;
        ex_ctrl_d  = CTRL_NOP;
        ex_rd_d    = {REG_ADDR_W{1'b0}};
      end
      mem_valid_d = ex_valid_q;
      mem_ctrl_d  = {ex_ctrl_q.mem_read, ex_ctrl_q.mem_write,
                     ex_ctrl_q.reg_wrt, ex_ctrl_q.wb_ctl};
      mem_rd_d    = ex_rd_q;
      wb_valid_d  = mem_valid_q;
      wb_ctrl_d   = {mem_ctrl_q.reg_wrt, mem_ctrl_q.wb_ctl};
      wb_rd_d     = mem_rd_q;
      ill_d       = ill_q || (accept_s && id_illegal_s);
    end
  end

  // Stage registers and sticky illegal flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid_q  <= 1'b0;
      ex_ctrl_q   <= CTRL_NOP;
      ex_rd_q     <= {REG_ADDR_W{1'b0}};
      mem_valid_q <= 1'b0;
      mem_ctrl_q  <= MEM_NOP;
      mem_rd_q    <= {REG_ADDR_W{1'b0}};
      wb_valid_q  <= 1'b0;
      wb_ctrl_q   <= WB_NOP;
      wb_rd_q     <= {REG_ADDR_W{1'b0}};
      ill_q       <= 1'b0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      ex_ctrl_q   <= ex_ctrl_d;
      ex_rd_q     <= ex_rd_d;
      mem_valid_q <= mem_valid_d;
      mem_ctrl_q  <= mem_ctrl_d;
      mem_rd_q    <= mem_rd_d;
      wb_valid_q  <= wb_valid_d;
      wb_ctrl_q   <= wb_ctrl_d;
      wb_rd_q     <= wb_rd_d;
      ill_q       <= ill_d;
    end
  end

  assign idReady      = ready_s;
  assign exValid      = ex_valid_q;
  assign exAluOp      = ALUOP_W'(ex_ctrl_q.alu_op);
  assign exAluSrc     = ex_ctrl_q.alu_src;
  assign exBranchZero = ex_ctrl_q.branch_zero;
  assign exBranchNeg  = ex_ctrl_q.branch_neg;
  assign exJump       = ex_ctrl_q.jump;
  assign exJumpMem    = ex_ctrl_q.jump_mem;
  assign exRd         = ex_rd_q;
  assign memValid     = mem_valid_q;
  assign memRead      = mem_ctrl_q.mem_read;
  assign memWrite     = mem_ctrl_q.mem_write;
  assign memRd        = mem_rd_q;
  assign wbValid      = wb_valid_q;
  assign wbControl    = wb_ctrl_q.wb_ctl;
  assign wbRegWrt     = wb_ctrl_q.reg_wrt;
  assign wbRd         = wb_rd_q;
  assign illegalOp    = ill_q;

endmodule

// File: doc/control_pipe.md
Name: control_pipe

Overview:
- Pipelined successor to the combinational opcode decoder.
- Decodes the ID-stage opcode, then carries control fields through registered EX, MEM and WB stages with valid bits.
- Inserts the load-use bubble, flushes on a taken branch or jump, and sequences the multi-cycle memory-indirect jump with a small FSM.
- Sits between the fetch/ID register and the datapath stage registers.

Parameters:
- OPCODE_W, 4: opcode field width. Legal opcodes use bits [3:0]; any set upper bit makes the opcode illegal.
- REG_ADDR_W, 6: register specifier width.
- ALUOP_W, 3: aluOp width, ≥3.
- JMEM_LAT, 2: cycles the memory read for jumpMem occupies, ≥1.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- idValid  in  1  ID stage holds a real instruction.
- opcode  in  OPCODE_W  ID-stage opcode.
- rd, rs, rt  in  REG_ADDR_W each  ID-stage register specifiers.
- memStall  in  1  data memory not ready; freezes the whole pipe.
- redirect  in  1  EX reports a taken branch or jump this cycle.
- idReady  out  1  ID instruction accepted this cycle.
- exValid, exAluOp[ALUOP_W], exAluSrc, exBranchZero, exBranchNeg, exJump, exJumpMem, exRd  out  EX-stage control.
- memValid, memRead, memWrite, memRd  out  MEM-stage control.
- wbValid, wbControl[2], wbRegWrt, wbRd  out  WB-stage control.
- illegalOp  out  1  sticky illegal-opcode flag.

Behaviour:
- Decode table, fixed in the package:
  - 1111 savepc: regWrt, wb=00.
  - 1110 load: memRead, regWrt, wb=01.
  - 0011 store: memWrite.
  - 0100 add: aluOp=100, regWrt, wb=10.
  - 0101 inc: aluOp=100, aluSrc, regWrt, wb=10.
  - 0110 neg: aluOp=010, regWrt, wb=10.
  - 0111 sub: aluOp=001, regWrt, wb=10.
  - 1000 jump: jump.
  - 1001 brz: aluOp=001, branchZero.
  - 1011 brn: aluOp=001, branchNeg.
  - 1010 jumpMem: memRead, jump, jumpMem.
  - 0000 nop: all zero.
  - Every field not listed is 0. aluOp is zero-extended to ALUOP_W.
- Reset: all outputs 0, except idReady=1. FSM enters RUN. illegalOp cleared.
- Latency: an accepted instruction appears on ex* the next cycle, mem* after 2 cycles and wb* after 3 cycles.
- A bubble is all control fields 0 with valid=0.
- memStall=1: all stage registers hold, idReady=0, FSM holds. memStall has priority over every other event.
- redirect=1 (no stall): the ID instruction is not accepted and EX loads a bubble. MEM and WB advance normally.
- FSM states:
  - RUN, normal issue.
    - Load-use: EX holds a valid load and exRd equals rs or rt of a valid ID instruction. Then idReady=0, EX gets a bubble, go to HAZ.
    - Accepted jumpMem: go to JMEM with counter = JMEM_LAT.
  - HAZ: lasts one cycle. Accepts ID normally and returns to RUN. redirect is still honoured in this state.
  - JMEM:
    - idReady=0 and EX loads bubbles.
    - Counter decrements each unstalled cycle.
    - At 0, return to RUN.
    - redirect during JMEM returns to RUN immediately.
- Priority within a cycle: memStall > redirect > load-use > normal issue.
- A flushed or bubbled instruction never sets illegalOp.

Optional Feature:
- Macro ILLEGAL_TRAP_EN.
- Defined:
  - Undefined opcodes, and opcodes with upper bits set, become bubbles.
  - They set illegalOp, which stays 1 until reset.
- Undefined:
  - Those opcodes decode as nop but stay valid and flow down the pipe.
  - illegalOp is tied to 0.

Decomposition:
- Package control_pkg:
  - opcode constants;
  - aluOp codes ADD=100, NEG=010, SUB=001;
  - wbControl codes PC=00, MEM=01, ALU=10;
  - packed struct ctrl_t holding all control fields;
  - FSM state enum {RUN, HAZ, JMEM}.
- One sub-module, control_decode: purely combinational opcode-to-ctrl_t table plus the illegal flag. Pipeline registers and FSM live in control_pipe.

Test Plan:
- Add (0100, rd=5) issued, no stalls:
  - exAluOp=100 and exRd=5 at cycle+1;
  - wbControl=10, wbRegWrt=1, wbRd=5 at cycle+3.
- Load rd=3, then add rs=3:
  - idReady=0 for one cycle;
  - exValid=0 bubble, then the add appears in EX one cycle later than normal.
- jumpMem with JMEM_LAT=2:
  - idReady low 2 cycles;
  - EX shows the jumpMem then 2 bubbles;
  - FSM back to RUN.
- redirect=1 while inc is in ID:
  - EX next cycle exValid=0;
  - the preceding MEM/WB contents still advance.
- memStall=1 for 3 cycles mid-stream:
  - all ex/mem/wb outputs frozen;
  - idReady=0;
  - resumes with no instruction lost or duplicated.
- Opcode 1100 issued with ILLEGAL_TRAP_EN defined: illegalOp=1 next cycle and exValid=0.
- Same opcode with the macro undefined: exValid=1 with all control fields 0 and illegalOp=0.
- Assert reset mid-stream: every valid drops to 0 immediately and idReady=1.
